// File: rtl/cfg_pkg.sv
// Shared types for the configuration scheduler: FSM state encoding and the
// packed configuration record used for the input, capture and shadow copies.
package cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STABLE   = 3'd1,
        ST_MUL_RX   = 3'd2,
        ST_MUL_TX   = 3'd3,
        ST_WAIT_BND = 3'd4,
        ST_APPLY    = 3'd5
    } state_t;

    localparam int SRATE_MAX = 2;

    typedef struct packed {
        logic [31:0] rx_freq;
        logic [31:0] tx_freq;
        logic [7:0]  s_rate;
        logic [7:0]  tx_level;
    } cfg_t;

endpackage

// File: rtl/cfg_scheduler_if.sv
// Register-side configuration inputs and applied datapath configuration outputs.
interface cfg_scheduler_if;

    logic [31:0] rx_freq_in;
    logic [31:0] tx_freq_in;
    logic [7:0]  s_rate_in;
    logic [7:0]  tx_level_in;
    logic        sample_stb;
    logic [31:0] rx_phase;
    logic [31:0] tx_phase;
    logic [1:0]  s_rate_code;
    logic [7:0]  tx_level;
    logic        cfg_upd;
    logic        busy;
    logic        srate_err;

    modport master (
        output rx_freq_in, tx_freq_in, s_rate_in, tx_level_in, sample_stb,
        input  rx_phase, tx_phase, s_rate_code, tx_level, cfg_upd, busy, srate_err
    );

    modport slave (
        input  rx_freq_in, tx_freq_in, s_rate_in, tx_level_in, sample_stb,
        output rx_phase, tx_phase, s_rate_code, tx_level, cfg_upd, busy, srate_err
    );

endinterface

// File: rtl/serial_mult32.sv
// 32x32 unsigned shift-add multiplier, one multiplier bit per clock.
// done pulses 32 clocks after the accepted start; starts while busy are dropped.
module serial_mult32 (
    input  logic        clock,
    input  logic        _reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        done,
    output logic [63:0] p
);

    logic [63:0] acc_reg;
    logic [63:0] mcand_reg;
    logic [31:0] mplier_reg;
    logic [4:0]  bit_cnt_reg;
    logic        busy_reg;
    logic        done_reg;

    // Bit 0 is folded into the start cycle so the final bit lands on the 31st busy edge.
    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            acc_reg     <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            bit_cnt_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (!busy_reg) begin
                if (start) begin
                    acc_reg     <= b[0] ? {32'd0, a} : 64'd0;
                    mcand_reg   <= {31'd0, a, 1'b0};
                    mplier_reg  <= {1'b0, b[31:1]};
                    bit_cnt_reg <= 5'd1;
                    busy_reg    <= 1'b1;
                end
            end else begin
                acc_reg     <= acc_reg + (mplier_reg[0] ? mcand_reg : 64'd0);
                mcand_reg   <= {mcand_reg[62:0], 1'b0};
                mplier_reg  <= {1'b0, mplier_reg[31:1]};
                bit_cnt_reg <= bit_cnt_reg + 5'd1;
                if (bit_cnt_reg == 5'd31) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign done = done_reg;
    assign p    = acc_reg;

endmodule

// File: rtl/cfg_scheduler.sv
// Debounces register-side configuration, converts frequencies to NCO phase
// increments on one shared multiplier and applies everything on a sample boundary.
module cfg_scheduler
    import cfg_pkg::*;
#(
    parameter int          STABLE_CNT = 16,
    parameter logic [31:0] K_MULT     = 32'd36_650_387,
    parameter int          K_SHIFT    = 20
) (
    input logic            clock,
    input logic            _reset,
    cfg_scheduler_if.slave bus
);

    localparam int CNT_W = $clog2(STABLE_CNT + 1);

    cfg_t             in_now;
    cfg_t             in_q_reg, in_prev_reg, cap_reg, shadow_reg;
    logic             shadow_valid_reg;
    logic [CNT_W-1:0] stab_cnt_reg;
    state_t           state_reg, state_next;
    logic             wait_armed_reg;
    logic [31:0]      rx_ph_reg, tx_ph_reg;
    logic [31:0]      rx_phase_reg, tx_phase_reg;
    logic [1:0]       s_rate_code_reg;
    logic [7:0]       tx_level_reg;
    logic             srate_err_reg;

    logic             stable_hit, at_shadow;
    logic             capture, store_rx, store_tx, apply_load;
    logic             mult_start, mult_done;
    logic [31:0]      mult_a;
    logic [63:0]      mult_p;
    logic [31:0]      ph_next;
    logic             unused_p_bits;

    assign in_now     = {bus.rx_freq_in, bus.tx_freq_in, bus.s_rate_in, bus.tx_level_in};
    assign stable_hit = (stab_cnt_reg == CNT_W'(STABLE_CNT));
    assign at_shadow  = shadow_valid_reg && (in_q_reg == shadow_reg);
    assign ph_next    = mult_p[K_SHIFT+31:K_SHIFT];
    assign unused_p_bits = ^{mult_p[63:K_SHIFT+32], mult_p[K_SHIFT-1:0]};

    serial_mult32 u_mult (
        .clock  (clock),
        ._reset (_reset),
        .start  (mult_start),
        .a      (mult_a),
        .b      (K_MULT),
        .done   (mult_done),
        .p      (mult_p)
    );

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        store_rx   = 1'b0;
        store_tx   = 1'b0;
        apply_load = 1'b0;
        mult_start = 1'b0;
        mult_a     = cap_reg.tx_freq;
        case (state_reg)
            ST_IDLE: if (!at_shadow) state_next = ST_STABLE;
            ST_STABLE: begin
                if (at_shadow) begin
                    state_next = ST_IDLE;
                end else if (stable_hit) begin
                    // cap is loaded this edge, so feed the multiplier straight from in_q
                    capture    = 1'b1;
                    mult_start = 1'b1;
                    mult_a     = in_q_reg.rx_freq;
                    state_next = ST_MUL_RX;
                end
            end
            ST_MUL_RX: if (mult_done) begin
                store_rx   = 1'b1;
                mult_start = 1'b1;
                state_next = ST_MUL_TX;
            end
            ST_MUL_TX: if (mult_done) begin
                store_tx   = 1'b1;
                state_next = ST_WAIT_BND;
            end
            ST_WAIT_BND: if (wait_armed_reg && bus.sample_stb) begin
                apply_load = 1'b1;
                state_next = ST_APPLY;
            end
            ST_APPLY: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            state_reg        <= ST_IDLE;
            in_q_reg         <= '0;
            in_prev_reg      <= '0;
            cap_reg          <= '0;
            shadow_reg       <= '0;
            shadow_valid_reg <= 1'b0;
            stab_cnt_reg     <= '0;
            wait_armed_reg   <= 1'b0;
            rx_ph_reg        <= '0;
            tx_ph_reg        <= '0;
            rx_phase_reg     <= '0;
            tx_phase_reg     <= '0;
            s_rate_code_reg  <= '0;
            tx_level_reg     <= '0;
            srate_err_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            in_q_reg    <= in_now;
            in_prev_reg <= in_q_reg;
            if (in_q_reg != in_prev_reg)
                stab_cnt_reg <= '0;
            else if (!stable_hit)
                stab_cnt_reg <= stab_cnt_reg + 1'b1;
            // The first WAIT_BND cycle is the transition cycle; its strobe is ignored.
            wait_armed_reg <= (state_reg == ST_WAIT_BND);
            if (capture)  cap_reg   <= in_q_reg;
            if (store_rx) rx_ph_reg <= ph_next;
            if (store_tx) tx_ph_reg <= ph_next;
            if (apply_load) begin
                rx_phase_reg <= rx_ph_reg;
                tx_phase_reg <= tx_ph_reg;
                tx_level_reg <= cap_reg.tx_level;
                if (cap_reg.s_rate <= 8'(SRATE_MAX))
                    s_rate_code_reg <= cap_reg.s_rate[1:0];
                else
                    srate_err_reg <= 1'b1;
            end
            if (state_reg == ST_APPLY) begin
                shadow_reg       <= cap_reg;
                shadow_valid_reg <= 1'b1;
            end
        end
    end

    assign bus.rx_phase    = rx_phase_reg;
    assign bus.tx_phase    = tx_phase_reg;
    assign bus.s_rate_code = s_rate_code_reg;
    assign bus.tx_level    = tx_level_reg;
    assign bus.cfg_upd     = (state_reg == ST_APPLY);
    assign bus.busy        = (state_reg != ST_IDLE);
    assign bus.srate_err   = srate_err_reg;

endmodule
